hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_hazard_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: stall/flush/forward control plus a multi-cycle multiply/divide hold sequencer.
// Optional macro HAZARD_FORWARD_EN enables bypass forwarding; without it every RAW producer in E/M stalls Decode.
module hazard_ctrl #(
   parameter int unsigned MD_LATENCY = 32
) (
   input  logic       clk,
   input  logic       RST_,
   input  logic [4:0] RsD,
   input  logic [4:0] RtD,
   input  logic [4:0] RsE,
   input  logic [4:0] RtE,
   input  logic [4:0] WriteRegE,
   input  logic [4:0] WriteRegM,
   input  logic [4:0] WriteRegW,
   input  logic       RegWriteE,
   input  logic       RegWriteM,
   input  logic       RegWriteW,
   input  logic       MemtoRegE,
   input  logic       MemtoRegM,
   input  logic       BranchD,
   input  logic       PCSrcD,
   input  logic       MDStartE,
   output logic       ENF_,
   output logic       END_,
   output logic       ENE_,
   output logic       FlushD,
   output logic       FlushE,
   output logic       FlushM,
   output logic [1:0] ForwardAE,
   output logic [1:0] ForwardBE,
   output logic       ForwardAD,
   output logic       ForwardBD,
   output logic       MDBusy
);

   localparam logic [0:0] RUN    = 1'b0;
   localparam logic [0:0] MDBUSY = 1'b1;
   localparam logic [7:0] MD_LOAD = 8'(MD_LATENCY - 1);

   logic [0:0] state_q, state_d;
   logic [7:0] MDCnt_q, MDCnt_d;
   logic       md_hold;
   logic       stall;

   // Nonzero destination w matches either Decode source.
   function automatic logic d_hit(input logic [4:0] w, input logic [4:0] a, input logic [4:0] b);
      return (w != 5'd0) && ((w == a) || (w == b));
   endfunction

   always_comb begin
      state_d = state_q;
      MDCnt_d = MDCnt_q;
      md_hold = 1'b0;
      case (state_q)
         RUN: begin
            if (MDStartE) begin
               state_d = MDBUSY;
               MDCnt_d = MD_LOAD;
               md_hold = 1'b1;
            end
         end
         MDBUSY: begin
            // The start cycle counts as the first hold cycle, so MDBUSY lasts MD_LATENCY-1 cycles.
            md_hold = 1'b1;
            MDCnt_d = MDCnt_q - 8'd1;
            if (MDCnt_q == 8'd1) state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge RST_) begin
      if (!RST_) begin
         state_q <= RUN;
         MDCnt_q <= 8'd0;
      end else begin
         state_q <= state_d;
         MDCnt_q <= MDCnt_d;
      end
   end

`ifdef HAZARD_FORWARD_EN
   logic lu_stall, br_stall;
   assign lu_stall = MemtoRegE && d_hit(RtE, RsD, RtD);
   assign br_stall = BranchD && ((RegWriteE && d_hit(WriteRegE, RsD, RtD)) ||
                                 (MemtoRegM && d_hit(WriteRegM, RsD, RtD)));
   assign stall    = lu_stall || br_stall;

   always_comb begin
      ForwardAE = 2'b00;
      if (RegWriteM && (WriteRegM != 5'd0) && (WriteRegM == RsE))      ForwardAE = 2'b10;
      else if (RegWriteW && (WriteRegW != 5'd0) && (WriteRegW == RsE)) ForwardAE = 2'b01;
   end

   always_comb begin
      ForwardBE = 2'b00;
      if (RegWriteM && (WriteRegM != 5'd0) && (WriteRegM == RtE))      ForwardBE = 2'b10;
      else if (RegWriteW && (WriteRegW != 5'd0) && (WriteRegW == RtE)) ForwardBE = 2'b01;
   end

   assign ForwardAD = RegWriteM && (WriteRegM != 5'd0) && (WriteRegM == RsD);
   assign ForwardBD = RegWriteM && (WriteRegM != 5'd0) && (WriteRegM == RtD);
`else
   // No bypass network: W results reach Decode through the register file, E/M results must wait.
   logic unused_nofwd;
   assign unused_nofwd = ^{RsE, RtE, WriteRegW, RegWriteW, MemtoRegE, MemtoRegM, BranchD};
   assign stall     = (RegWriteE && d_hit(WriteRegE, RsD, RtD)) ||
                      (RegWriteM && d_hit(WriteRegM, RsD, RtD));
   assign ForwardAE = 2'b00;
   assign ForwardBE = 2'b00;
   assign ForwardAD = 1'b0;
   assign ForwardBD = 1'b0;
`endif

   always_comb begin
      ENF_   = 1'b0;
      END_   = 1'b0;
      ENE_   = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushM = 1'b0;
      if (md_hold) begin
         ENF_   = 1'b1;
         END_   = 1'b1;
         ENE_   = 1'b1;
         FlushM = 1'b1;
      end else if (stall) begin
         ENF_   = 1'b1;
         END_   = 1'b1;
         FlushE = 1'b1;
      end else begin
         FlushD = PCSrcD;
      end
   end

   assign MDBusy = (state_q == MDBUSY);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl (MD_LATENCY=4): vector table for combinational hazards, hand sequences for MD hold and reset.
module tb_hazard_ctrl;

   typedef struct packed {
      logic [4:0] rsd, rtd, rse, rte, wre, wrm, wrw;
      logic       rwe, rwm, rww, mre, mrm, br, pcs, md;
   } in_t;

   typedef struct packed {
      logic       enf, en_d, ene, fd, fe, fm, busy;
      logic [1:0] fae, fbe;
      logic       fad, fbd;
   } out_t;

   typedef struct {
      string name;
      in_t   i;
      out_t  e_fw;
      out_t  e_nf;
   } vec_t;

   logic       clk = 1'b0;
   logic       RST_;
   logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
   logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD, PCSrcD, MDStartE;
   logic       ENF_, END_, ENE_, FlushD, FlushE, FlushM, ForwardAD, ForwardBD, MDBusy;
   logic [1:0] ForwardAE, ForwardBE;

   int n_cmp = 0;
   int n_bad = 0;
   out_t  exp_q[$];
   string nm_q[$];
   vec_t  vt[15];

   hazard_ctrl #(.MD_LATENCY(4)) dut (
      .clk(clk), .RST_(RST_),
      .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
      .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
      .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
      .BranchD(BranchD), .PCSrcD(PCSrcD), .MDStartE(MDStartE),
      .ENF_(ENF_), .END_(END_), .ENE_(ENE_),
      .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .MDBusy(MDBusy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got no summary, required finish before time limit");
      $fatal(1);
   end

   function automatic in_t vin(input logic [4:0] rsd, rtd, rse, rte, wre, wrm, wrw,
                               input logic rwe, rwm, rww, mre, mrm, br, pcs, md);
      in_t v;
      v.rsd = rsd; v.rtd = rtd; v.rse = rse; v.rte = rte;
      v.wre = wre; v.wrm = wrm; v.wrw = wrw;
      v.rwe = rwe; v.rwm = rwm; v.rww = rww; v.mre = mre; v.mrm = mrm;
      v.br = br; v.pcs = pcs; v.md = md;
      return v;
   endfunction

   // RUN-state outputs: a stall raises ENF_, END_ and FlushE together.
   function automatic out_t o(input logic st, fd, input logic [1:0] fae, fbe, input logic fad, fbd);
      out_t r;
      r = '0;
      r.enf = st; r.en_d = st; r.fe = st; r.fd = fd;
      r.fae = fae; r.fbe = fbe; r.fad = fad; r.fbd = fbd;
      return r;
   endfunction

   // MD hold outputs with no forwarding-relevant inputs.
   function automatic out_t omd(input logic busy);
      out_t r;
      r = '0;
      r.enf = 1'b1; r.en_d = 1'b1; r.ene = 1'b1; r.fm = 1'b1; r.busy = busy;
      return r;
   endfunction

   task automatic drive(input in_t v, input out_t e, input string n);
      RsD = v.rsd; RtD = v.rtd; RsE = v.rse; RtE = v.rte;
      WriteRegE = v.wre; WriteRegM = v.wrm; WriteRegW = v.wrw;
      RegWriteE = v.rwe; RegWriteM = v.rwm; RegWriteW = v.rww;
      MemtoRegE = v.mre; MemtoRegM = v.mrm;
      BranchD = v.br; PCSrcD = v.pcs; MDStartE = v.md;
      exp_q.push_back(e);
      nm_q.push_back(n);
   endtask

   task automatic check();
      out_t g, e;
      string n;
      g.enf = ENF_; g.en_d = END_; g.ene = ENE_; g.fd = FlushD; g.fe = FlushE; g.fm = FlushM;
      g.busy = MDBusy; g.fae = ForwardAE; g.fbe = ForwardBE; g.fad = ForwardAD; g.fbd = ForwardBD;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_bad++;
         $display("FAIL scoreboard_empty: got %b, required a queued expectation", g);
      end else begin
         e = exp_q.pop_front();
         n = nm_q.pop_front();
         if (g !== e) begin
            n_bad++;
            $display("FAIL %s: got enf%b end%b ene%b fd%b fe%b fm%b busy%b fae%b fbe%b fad%b fbd%b, required %b%b%b%b%b%b%b %b %b %b%b",
                     n, g.enf, g.en_d, g.ene, g.fd, g.fe, g.fm, g.busy, g.fae, g.fbe, g.fad, g.fbd,
                     e.enf, e.en_d, e.ene, e.fd, e.fe, e.fm, e.busy, e.fae, e.fbe, e.fad, e.fbd);
         end
      end
   endtask

   task automatic step(input in_t v, input out_t e, input string n);
      @(posedge clk);
      #1 drive(v, e, n);
      @(negedge clk);
      check();
   endtask

   function automatic out_t sel(input vec_t v);
`ifdef HAZARD_FORWARD_EN
      return v.e_fw;
`else
      return v.e_nf;
`endif
   endfunction

   in_t z, lu, lu_pcs;

   initial begin
      z      = vin(0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0);
      lu     = vin(5,0,0,5,5,0,0, 1,0,0,1,0,0,0,0);
      lu_pcs = vin(5,0,0,5,5,0,0, 1,0,0,1,0,0,1,0);
      //             name          rsd rtd rse rte wre wrm wrw rwe rwm rww mre mrm br pcs md
      vt[0]  = '{"idle",        z,                                                o(0,0,0,0,0,0), o(0,0,0,0,0,0)};
      vt[1]  = '{"load_use",    lu,                                               o(1,0,0,0,0,0), o(1,0,0,0,0,0)};
      vt[2]  = '{"lu_release",  vin(5,0,0,0,0,0,0, 0,0,0,0,0,0,0,0),              o(0,0,0,0,0,0), o(0,0,0,0,0,0)};
      vt[3]  = '{"fwdAE_MoverW",vin(0,0,8,0,0,8,8, 0,1,1,0,0,0,0,0),              o(0,0,2,0,0,0), o(0,0,0,0,0,0)};
      vt[4]  = '{"fwdAE_r0",    vin(0,0,0,0,0,0,0, 0,1,0,0,0,0,0,0),              o(0,0,0,0,0,0), o(0,0,0,0,0,0)};
      vt[5]  = '{"fwdBE_W",     vin(0,0,0,9,0,0,9, 0,0,1,0,0,0,0,0),              o(0,0,0,1,0,0), o(0,0,0,0,0,0)};
      vt[6]  = '{"redirect",    vin(0,0,0,0,0,0,0, 0,0,0,0,0,0,1,0),              o(0,1,0,0,0,0), o(0,1,0,0,0,0)};
      vt[7]  = '{"redir_in_lu", lu_pcs,                                           o(1,0,0,0,0,0), o(1,0,0,0,0,0)};
      vt[8]  = '{"M_vs_RtD",    vin(0,3,0,0,0,3,0, 0,1,0,0,0,0,0,0),              o(0,0,0,0,0,1), o(1,0,0,0,0,0)};
      vt[9]  = '{"br_E_stall",  vin(4,0,0,0,4,0,0, 1,0,0,0,0,1,0,0),              o(1,0,0,0,0,0), o(1,0,0,0,0,0)};
      vt[10] = '{"br_Mld_stall",vin(0,6,0,0,0,6,0, 0,1,0,0,1,1,0,0),              o(1,0,0,0,0,1), o(1,0,0,0,0,0)};
      vt[11] = '{"reg0_none",   vin(0,0,0,0,0,0,0, 1,1,1,1,0,0,0,0),              o(0,0,0,0,0,0), o(0,0,0,0,0,0)};
      vt[12] = '{"W_vs_D",      vin(7,0,0,0,0,0,7, 0,0,1,0,0,0,0,0),              o(0,0,0,0,0,0), o(0,0,0,0,0,0)};
      vt[13] = '{"fwdBE_MoverW",vin(0,0,0,10,0,10,10, 0,1,1,0,0,0,0,0),           o(0,0,0,2,0,0), o(0,0,0,0,0,0)};
      vt[14] = '{"br_W_only",   vin(11,0,0,0,0,0,11, 0,0,1,0,0,1,0,0),            o(0,0,0,0,0,0), o(0,0,0,0,0,0)};

      RST_ = 1'b0;
      drive(z, o(0,0,0,0,0,0), "reset_state");
      #1 check();
      @(negedge clk);
      RST_ = 1'b1;

      for (int k = 0; k < 15; k++) step(vt[k].i, sel(vt[k]), vt[k].name);

      // MD pulse: four hold cycles, busy on cycles 2..4, stall/redirect requests masked.
      step(vin(0,0,0,0,0,0,0, 0,0,0,0,0,0,1,1), omd(0), "md_c1");
      step(z,      omd(1), "md_c2");
      step(lu_pcs, omd(1), "md_c3_prio");
      step(z,      omd(1), "md_c4");
      step(z,      o(0,0,0,0,0,0), "md_done");

      // A second start request while busy must not reload the counter.
      step(vin(0,0,0,0,0,0,0, 0,0,0,0,0,0,0,1), omd(0), "md2_c1");
      step(vin(0,0,0,0,0,0,0, 0,0,0,0,0,0,0,1), omd(1), "md2_c2_restart");
      step(z, omd(1), "md2_c3");
      step(z, omd(1), "md2_c4");
      step(z, o(0,0,0,0,0,0), "md2_done");
      step(lu, o(1,0,0,0,0,0), "after_md_lu");

      // Reset asserted on the second hold cycle aborts the sequence immediately.
      step(vin(0,0,0,0,0,0,0, 0,0,0,0,0,0,0,1), omd(0), "rst_c1");
      step(z, omd(1), "rst_c2");
      #1 RST_ = 1'b0;
      drive(z, o(0,0,0,0,0,0), "rst_abort");
      #1 check();
      @(posedge clk);
      #1 RST_ = 1'b1;
      drive(z, o(0,0,0,0,0,0), "post_rst");
      @(negedge clk);
      check();
      step(z,  o(0,0,0,0,0,0), "post_rst2");
      step(lu, o(1,0,0,0,0,0), "post_rst_lu");

      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL scoreboard_leftover: got %0d pending, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
